// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the single-port memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF     = 32;
    localparam int DATA_W_DEF     = 32;
    localparam int STARVE_MAX_DEF = 4;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISERV = 2'd1,
        ARB_DSERV = 2'd2
    } arb_state_t;

    // A data request is pending for either a read or a write.
    function automatic logic data_pending(input logic ren, input logic wen);
        return ren | wen;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and RAM-side signals of the memory arbiter, grouped as one bundle.
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              iREN;
    logic [ADDR_W-1:0] iaddr;
    logic              ihit;
    logic [DATA_W-1:0] iload;
    logic              dREN;
    logic              dWEN;
    logic [ADDR_W-1:0] daddr;
    logic [DATA_W-1:0] dstore;
    logic              dhit;
    logic [DATA_W-1:0] dload;
    logic              ramREN;
    logic              ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    logic [DATA_W-1:0] ramstore;
    logic [DATA_W-1:0] ramload;
    logic              ramready;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
        output ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
        input  ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/arb_starve_ctr.sv
// Saturating count of data grants made while a fetch is waiting.
module arb_starve_ctr #(
    parameter int STARVE_MAX = 4,
    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1)
) (
    input  logic CLK,
    input  logic RST,
    input  logic inc,
    input  logic clr,
    output logic at_max
);
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_max_s;

    assign at_max_s = (cnt_q == CNT_W'(STARVE_MAX));
    assign at_max   = at_max_s;

    // Clear wins over increment; increment stops at the ceiling.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (inc && !at_max_s) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data requests onto one RAM port: data first, fetch
// forced through after STARVE_MAX data grants while it waits.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic          CLK,
    input  logic          RST,
    mem_arbiter_if.slave  bus
);
    arb_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] store_q, store_d;
    logic              wflag_q, wflag_d;
    logic              d_req_s;
    logic              ihit_s;
    logic              dhit_s;
    logic              inc_s;
    logic              clr_s;
    logic              at_max_s;

    arb_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
        .CLK    (CLK),
        .RST    (RST),
        .inc    (inc_s),
        .clr    (clr_s),
        .at_max (at_max_s)
    );

    assign d_req_s = data_pending(bus.dREN, bus.dWEN);
    // A hit needs the requester still holding its request when RAM completes.
    assign ihit_s  = (state_q == ARB_ISERV) && bus.ramready && bus.iREN;
    assign dhit_s  = (state_q == ARB_DSERV) && bus.ramready && d_req_s;

    // Next-state, grant latching and starvation bookkeeping.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        store_d = store_q;
        wflag_d = wflag_q;
        inc_s   = 1'b0;
        clr_s   = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (d_req_s && !(bus.iREN && at_max_s)) begin
                    state_d = ARB_DSERV;
                    addr_d  = bus.daddr;
                    store_d = bus.dstore;
                    wflag_d = bus.dWEN;
                    inc_s   = bus.iREN;
                    clr_s   = ~bus.iREN;
                end else if (bus.iREN) begin
                    state_d = ARB_ISERV;
                    addr_d  = bus.iaddr;
                    clr_s   = 1'b1;
                end else begin
                    clr_s   = 1'b1;
                end
            end
            ARB_ISERV: begin
                if (bus.ramready || !bus.iREN) begin
                    state_d = ARB_IDLE;
                end else begin
                    state_d = ARB_ISERV;
                end
            end
            ARB_DSERV: begin
                if (bus.ramready || !d_req_s) begin
                    state_d = ARB_IDLE;
                end else begin
                    state_d = ARB_DSERV;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State and holding registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ARB_IDLE;
            addr_q  <= {ADDR_W{1'b0}};
            store_q <= {DATA_W{1'b0}};
            wflag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            store_q <= store_d;
            wflag_q <= wflag_d;
        end
    end

    assign bus.ihit     = ihit_s;
    assign bus.dhit     = dhit_s;
    assign bus.iload    = ihit_s ? bus.ramload : {DATA_W{1'b0}};
    assign bus.dload    = (dhit_s && !wflag_q) ? bus.ramload : {DATA_W{1'b0}};
    assign bus.ramREN   = (state_q == ARB_ISERV) || ((state_q == ARB_DSERV) && !wflag_q);
    assign bus.ramWEN   = (state_q == ARB_DSERV) && wflag_q;
    assign bus.ramaddr  = addr_q;
    assign bus.ramstore = store_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a transaction-level reference model.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SMAX = 4;

    typedef struct {
        bit          wr;
        logic [31:0] a;
        logic [31:0] s;
    } dreq_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_s(input string name, input string act, input string exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%s required=%s", name, act, exp);
        end
    endtask

    // RAM responder: ready once the enable has been up for ram_lat earlier cycles
    int          ram_lat   = 0;
    int          wait_cnt  = 0;
    logic [31:0] ram_rdata = 32'h0;
    wire         ram_en    = bus.ramREN | bus.ramWEN;
    assign bus.ramready = ram_en && (wait_cnt >= ram_lat);
    assign bus.ramload  = ram_rdata;

    initial forever begin
        @(posedge CLK or posedge RST);
        wait_cnt <= (RST || !ram_en) ? 0 : wait_cnt + 1;
    end

    // Requester driver: queues when drv_en, manual values otherwise
    logic [31:0] fq[$];
    dreq_t       dq[$];
    bit          drv_en = 1'b1;
    logic        man_iren = 1'b0, man_dren = 1'b0, man_dwen = 1'b0;
    logic [31:0] man_iaddr = 32'h0, man_daddr = 32'h0, man_dstore = 32'h0;
    bit          ih_seen = 1'b0, dh_seen = 1'b0;

    initial begin
        logic [31:0] junk_a;
        dreq_t       junk_d;
        bus.iREN = 1'b0; bus.iaddr = 32'h0;
        bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.daddr = 32'h0; bus.dstore = 32'h0;
        forever begin
            @(posedge CLK);
            #1;
            if (drv_en) begin
                if (ih_seen && fq.size() > 0) junk_a = fq.pop_front();
                if (dh_seen && dq.size() > 0) junk_d = dq.pop_front();
                bus.iREN  = (fq.size() > 0);
                bus.iaddr = (fq.size() > 0) ? fq[0] : 32'h0;
                if (dq.size() > 0) begin
                    bus.dREN = !dq[0].wr; bus.dWEN = dq[0].wr;
                    bus.daddr = dq[0].a;  bus.dstore = dq[0].s;
                end else begin
                    bus.dREN = 1'b0; bus.dWEN = 1'b0;
                end
            end else begin
                bus.iREN = man_iren; bus.iaddr = man_iaddr;
                bus.dREN = man_dren; bus.dWEN = man_dwen;
                bus.daddr = man_daddr; bus.dstore = man_dstore;
            end
        end
    end

    // Reference model: who is being served, what was latched, starvation count
    int          m_serv = 0;   // 0 none, 1 fetch, 2 data
    logic [31:0] m_addr = 32'h0, m_store = 32'h0;
    bit          m_wr = 1'b0;
    int          m_starve = 0;

    initial forever begin
        bit dreq;
        @(posedge CLK or posedge RST);
        if (RST) begin
            m_serv = 0; m_addr = 32'h0; m_store = 32'h0; m_wr = 1'b0; m_starve = 0;
        end else begin
            dreq = bus.dREN | bus.dWEN;
            if (m_serv == 0) begin
                if (dreq && !(bus.iREN && m_starve == SMAX)) begin
                    m_serv = 2; m_addr = bus.daddr; m_store = bus.dstore; m_wr = bus.dWEN;
                    m_starve = bus.iREN ? ((m_starve < SMAX) ? m_starve + 1 : SMAX) : 0;
                end else if (bus.iREN) begin
                    m_serv = 1; m_addr = bus.iaddr; m_starve = 0;
                end else begin
                    m_starve = 0;
                end
            end else if (m_serv == 1) begin
                if (bus.ramready || !bus.iREN) m_serv = 0;
            end else begin
                if (bus.ramready || !dreq) m_serv = 0;
            end
        end
    end

    // Per-cycle compare against the model, plus a record of completed hits
    int          cyc = 0, i_cyc = 0, d_cyc = 0, dhit_cnt = 0, ren_cnt = 0;
    string       hitlog = "";
    logic [31:0] last_iload, last_iaddr, last_dload, last_daddr, last_dstore;
    logic        last_iren, last_dwen;

    initial forever begin
        bit          dreq, e_ih, e_dh;
        logic [31:0] e_il, e_dl;
        @(negedge CLK);
        cyc++;
        dreq = bus.dREN | bus.dWEN;
        e_ih = (m_serv == 1) && bus.ramready && bus.iREN;
        e_dh = (m_serv == 2) && bus.ramready && dreq;
        e_il = e_ih ? bus.ramload : 32'h0;
        e_dl = (e_dh && !m_wr) ? bus.ramload : 32'h0;
        chk("ihit",     bus.ihit,     e_ih);
        chk("dhit",     bus.dhit,     e_dh);
        chk("iload",    bus.iload,    e_il);
        chk("dload",    bus.dload,    e_dl);
        chk("ramREN",   bus.ramREN,   (m_serv == 1) || (m_serv == 2 && !m_wr));
        chk("ramWEN",   bus.ramWEN,   (m_serv == 2) && m_wr);
        chk("ramaddr",  bus.ramaddr,  m_addr);
        chk("ramstore", bus.ramstore, m_store);
        ih_seen = bus.ihit;
        dh_seen = bus.dhit;
        if (bus.ramREN) ren_cnt++;
        if (bus.ihit) begin
            hitlog = {hitlog, "I"}; i_cyc = cyc;
            last_iload = bus.iload; last_iaddr = bus.ramaddr; last_iren = bus.ramREN;
        end
        if (bus.dhit) begin
            hitlog = {hitlog, "D"}; d_cyc = cyc; dhit_cnt++;
            last_dload = bus.dload; last_daddr = bus.ramaddr;
            last_dstore = bus.ramstore; last_dwen = bus.ramWEN;
        end
    end

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while ((fq.size() > 0 || dq.size() > 0) && n < budget) begin
            @(posedge CLK);
            n++;
        end
        chk({name, "_timeout"}, (n >= budget), 1'b0);
        repeat (3) @(posedge CLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        int dh0;
        // Reset state
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_ramREN", bus.ramREN, 1'b0);
        chk("rst_ramWEN", bus.ramWEN, 1'b0);
        chk("rst_ramaddr", bus.ramaddr, 32'h0);
        chk("rst_ihit", bus.ihit, 1'b0);
        #2 RST = 1'b0;

        // Lone fetch, RAM ready in the first serve cycle
        @(negedge CLK);
        ram_lat = 0; ram_rdata = 32'hDEADBEEF; hitlog = ""; ren_cnt = 0;
        fq.push_back(32'h40);
        wait_done("lone", 20);
        chk_s("lone_order", hitlog, "I");
        chk("lone_iload", last_iload, 32'hDEADBEEF);
        chk("lone_ramaddr", last_iaddr, 32'h40);
        chk("lone_ramREN", last_iren, 1'b1);
        chk("lone_ren_cycles", ren_cnt, 1);

        // Simultaneous fetch and write: data first, one idle turnaround
        @(negedge CLK);
        ram_rdata = 32'h5555AAAA; hitlog = "";
        dq.push_back('{wr: 1'b1, a: 32'h80, s: 32'h1234});
        fq.push_back(32'h44);
        wait_done("simul", 30);
        chk_s("simul_order", hitlog, "DI");
        chk("simul_ramWEN", last_dwen, 1'b1);
        chk("simul_ramstore", last_dstore, 32'h1234);
        chk("simul_ramaddr", last_daddr, 32'h80);
        chk("simul_dload_wr", last_dload, 32'h0);
        chk("simul_gap", i_cyc - d_cyc, 2);
        chk("simul_iaddr", last_iaddr, 32'h44);

        // Starvation: fetch held against six back-to-back writes
        @(negedge CLK);
        hitlog = "";
        fq.push_back(32'h48);
        for (int i = 0; i < 6; i++) dq.push_back('{wr: 1'b1, a: 32'h100 + 32'(i * 4), s: 32'(i)});
        wait_done("starve", 100);
        chk_s("starve_order", hitlog, "DDDDIDD");

        // Address change mid-service is ignored
        drv_en = 1'b0;
        @(negedge CLK);
        ram_lat = 3; ram_rdata = 32'hCAFE0001;
        man_dren = 1'b1; man_daddr = 32'h80;
        @(negedge CLK);
        man_daddr = 32'h90;
        got = 1'b0;
        for (int k = 0; k < 12 && !got; k++) begin
            @(negedge CLK);
            chk("hold_ramaddr", bus.ramaddr, 32'h80);
            if (bus.dhit) begin
                got = 1'b1;
                chk("hold_dload", bus.dload, 32'hCAFE0001);
                chk("hold_latency", k, 3);
            end
        end
        chk("hold_seen_dhit", got, 1'b1);
        man_dren = 1'b0;
        repeat (2) @(negedge CLK);

        // Abort: read dropped before ramready
        ram_lat = 10; dh0 = dhit_cnt;
        man_dren = 1'b1; man_daddr = 32'h300;
        repeat (2) @(negedge CLK);
        chk("abort_ramREN_on", bus.ramREN, 1'b1);
        man_dren = 1'b0;
        @(negedge CLK);
        chk("abort_dhit", bus.dhit, 1'b0);
        @(negedge CLK);
        chk("abort_ramREN_off", bus.ramREN, 1'b0);
        chk("abort_no_hit", dhit_cnt - dh0, 0);
        drv_en = 1'b1;
        ram_lat = 0; ram_rdata = 32'h0BADF00D; hitlog = "";
        fq.push_back(32'h50);
        wait_done("after_abort", 20);
        chk_s("after_abort_order", hitlog, "I");
        chk("after_abort_iload", last_iload, 32'h0BADF00D);

        // Reset in the middle of a write service
        drv_en = 1'b0;
        @(negedge CLK);
        ram_lat = 10; dh0 = dhit_cnt;
        man_dwen = 1'b1; man_daddr = 32'h200; man_dstore = 32'h77;
        repeat (2) @(negedge CLK);
        chk("rstmid_ramWEN_on", bus.ramWEN, 1'b1);
        chk("rstmid_ramaddr_on", bus.ramaddr, 32'h200);
        #2 RST = 1'b1;
        #1;
        chk("rstmid_ramWEN", bus.ramWEN, 1'b0);
        chk("rstmid_ramaddr", bus.ramaddr, 32'h0);
        chk("rstmid_ramstore", bus.ramstore, 32'h0);
        chk("rstmid_dhit", bus.dhit, 1'b0);
        man_dwen = 1'b0;
        repeat (2) @(negedge CLK);
        #2 RST = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rstmid_no_hit", dhit_cnt - dh0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
